fetch_issue_queue: RTL and testbench

- Small in-order instruction queue directly downstream of the fetch stage, feeding decode/scoreboard issue.
- Captures fetch output (pc, instr, predicted_outcome), decouples issue stalls from fetch via a registered freeze, and discards wrong-path work on flush.
- Fetch presents pc=0/instr=0 as a bubble; the queue never stores bubbles.

---
 rtl/fetch_issue_queue.sv | 128 ++++++++++++
 tb/tb_fetch_issue_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_issue_queue.sv
// rtl/fetch_issue_queue.sv - in-order fetch-to-issue queue with flush, halt and optional bypass (FETCH_ISSUE_QUEUE_BYPASS_EN)
module fetch_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WORD_W-1:0]        in_pc,
    input  logic [WORD_W-1:0]        in_instr,
    input  logic                     in_pred,
    input  logic                     flush,
    input  logic                     halt,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WORD_W-1:0]        out_pc,
    output logic [WORD_W-1:0]        out_instr,
    output logic                     out_pred,
    output logic                     freeze,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_W-1:0] pc_mem    [DEPTH];
    logic [WORD_W-1:0] instr_mem [DEPTH];
    logic              pred_mem  [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] occ;
    logic          halted;

    logic          full;
    logic          q_valid;
    logic          enq_ok;
    logic          do_wr;
    logic          do_deq;

    // Freeze is decoded from registered state only so fetch never sees a same-cycle input path.
    assign full    = (occ == CW'(DEPTH)) && !halted;
    assign freeze  = full;
    assign count   = occ;
    assign q_valid = (occ != '0) && !halted;
    assign enq_ok  = (in_instr != '0) && !full && !flush && !halted;
    assign do_deq  = q_valid && out_ready && !flush;

`ifdef FETCH_ISSUE_QUEUE_BYPASS_EN
    logic byp;

    // Bypass hands an incoming instruction straight to issue when the queue is empty;
    // this creates a combinational in_* to out_* path that timing must account for.
    assign byp   = (occ == '0) && enq_ok && out_ready;
    assign do_wr = enq_ok && !byp;

    // Head mux: bypassed input takes priority, otherwise the entry at rd_ptr.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        out_pred  = 1'b0;
        if (byp) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
            out_pred  = in_pred;
        end else if (q_valid) begin
            out_valid = 1'b1;
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
            out_pred  = pred_mem[rd_ptr];
        end
    end
`else
    assign do_wr = enq_ok;

    // Head outputs come only from registered storage, gated to zero when nothing is valid.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        out_pred  = 1'b0;
        if (q_valid) begin
            out_valid = 1'b1;
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
            out_pred  = pred_mem[rd_ptr];
        end
    end
`endif

    // Pointer, occupancy and sticky halt tracking; flush collapses the queue to empty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            halted <= 1'b0;
        end else begin
            if (halt) begin
                halted <= 1'b1;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                occ    <= '0;
            end else begin
                if (do_wr) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (do_deq) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                occ <= occ + CW'(do_wr) - CW'(do_deq);
            end
        end
    end

    // Entry storage needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge CLK) begin
        if (do_wr) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
            pred_mem[wr_ptr]  <= in_pred;
        end
    end

endmodule

// File: tb/tb_fetch_issue_queue.sv
// tb/tb_fetch_issue_queue.sv - directed vector bench for fetch_issue_queue
module tb_fetch_issue_queue;

    localparam int DEPTH  = 4;
    localparam int WORD_W = 32;
    localparam logic [31:0] IMASK = 32'hC0DE_0000;

    logic              CLK = 1'b0;
    logic              RST;
    logic [WORD_W-1:0] in_pc;
    logic [WORD_W-1:0] in_instr;
    logic              in_pred;
    logic              flush;
    logic              halt;
    logic              out_ready;
    logic              out_valid;
    logic [WORD_W-1:0] out_pc;
    logic [WORD_W-1:0] out_instr;
    logic              out_pred;
    logic              freeze;
    logic [2:0]        count;

    int checks = 0;
    int errors = 0;

    fetch_issue_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_pred   (in_pred),
        .flush     (flush),
        .halt      (halt),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_pred  (out_pred),
        .freeze    (freeze),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        halt;
        logic        ready;
        logic [31:0] pc;
        logic        bubble;
        logic        e_valid;
        logic [31:0] e_pc;
        int          e_cnt;
        logic        e_frz;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic fl, input logic hl, input logic rdy,
                       input logic [31:0] pc, input logic bub,
                       input logic ev, input logic [31:0] epc, input int ecnt, input logic efrz);
        vec_t v;
        v.rst = rst; v.flush = fl; v.halt = hl; v.ready = rdy;
        v.pc = pc; v.bubble = bub;
        v.e_valid = ev; v.e_pc = epc; v.e_cnt = ecnt; v.e_frz = efrz;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic hl, input logic rdy,
                         input logic [31:0] pc, input logic bub);
        RST       = rst;
        flush     = fl;
        halt      = hl;
        out_ready = rdy;
        in_pc     = pc;
        in_instr  = (bub || pc == 0) ? 32'h0 : (pc ^ IMASK);
        in_pred   = pc[2];
    endtask

    task automatic check_head(input string tag, input logic ev, input logic [31:0] epc,
                              input int ecnt, input logic efrz);
        check({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, ev});
        check({tag, " out_pc"},    out_pc,    ev ? epc : 32'h0);
        check({tag, " out_instr"}, out_instr, ev ? (epc ^ IMASK) : 32'h0);
        check({tag, " out_pred"},  {31'b0, out_pred}, {31'b0, ev & epc[2]});
        check({tag, " freeze"},    {31'b0, freeze},   {31'b0, efrz});
        check({tag, " count"},     {29'b0, count},    ecnt[31:0]);
    endtask

    initial begin
        int q[$];
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // reset and stream
        add(1,0,0,0, 32'h0,   1, 0, 32'h0,   0, 0);
        add(1,0,0,0, 32'h0,   1, 0, 32'h0,   0, 0);
        add(0,0,0,1, 32'h100, 0, 1, 32'h100, 1, 0);
        add(0,0,0,1, 32'h104, 0, 1, 32'h104, 1, 0);
        add(0,0,0,1, 32'h108, 0, 1, 32'h108, 1, 0);
        add(0,0,0,1, 32'h0,   1, 0, 32'h0,   0, 0);
        // fill and freeze
        add(0,0,0,0, 32'h200, 0, 1, 32'h200, 1, 0);
        add(0,0,0,0, 32'h204, 0, 1, 32'h200, 2, 0);
        add(0,0,0,0, 32'h208, 0, 1, 32'h200, 3, 0);
        add(0,0,0,0, 32'h20C, 0, 1, 32'h200, 4, 1);
        add(0,0,0,0, 32'h210, 0, 1, 32'h200, 4, 1);
        add(0,0,0,1, 32'h210, 0, 1, 32'h204, 3, 0);
        add(0,0,0,0, 32'h210, 0, 1, 32'h204, 4, 1);
        add(0,0,0,1, 32'h0,   1, 1, 32'h208, 3, 0);
        add(0,0,0,1, 32'h0,   1, 1, 32'h20C, 2, 0);
        add(0,0,0,1, 32'h0,   1, 1, 32'h210, 1, 0);
        add(0,0,0,1, 32'h0,   1, 0, 32'h0,   0, 0);
        // bubbles
        add(0,0,0,0, 32'h300, 0, 1, 32'h300, 1, 0);
        add(0,0,0,0, 32'h302, 1, 1, 32'h300, 1, 0);
        add(0,0,0,0, 32'h304, 0, 1, 32'h300, 2, 0);
        add(0,0,0,0, 32'h0,   1, 1, 32'h300, 2, 0);
        add(0,0,0,1, 32'h0,   1, 1, 32'h304, 1, 0);
        add(0,0,0,1, 32'h0,   1, 0, 32'h0,   0, 0);
        // flush mid-stream
        add(0,0,0,0, 32'h380, 0, 1, 32'h380, 1, 0);
        add(0,0,0,0, 32'h384, 0, 1, 32'h380, 2, 0);
        add(0,0,0,0, 32'h388, 0, 1, 32'h380, 3, 0);
        add(0,1,0,1, 32'h400, 0, 0, 32'h0,   0, 0);
        add(0,0,0,0, 32'h500, 0, 1, 32'h500, 1, 0);
        add(0,0,0,1, 32'h0,   1, 0, 32'h0,   0, 0);
        // flush while full
        add(0,0,0,0, 32'h600, 0, 1, 32'h600, 1, 0);
        add(0,0,0,0, 32'h604, 0, 1, 32'h600, 2, 0);
        add(0,0,0,0, 32'h608, 0, 1, 32'h600, 3, 0);
        add(0,0,0,0, 32'h60C, 0, 1, 32'h600, 4, 1);
        add(0,1,0,0, 32'h0,   1, 0, 32'h0,   0, 0);
        // halt then reset
        add(0,0,0,0, 32'h700, 0, 1, 32'h700, 1, 0);
        add(0,0,0,0, 32'h704, 0, 1, 32'h700, 2, 0);
        add(0,0,1,0, 32'h0,   1, 0, 32'h0,   2, 0);
        add(0,0,0,1, 32'h710, 0, 0, 32'h0,   2, 0);
        add(0,0,0,1, 32'h714, 0, 0, 32'h0,   2, 0);
        add(1,0,0,0, 32'h0,   1, 0, 32'h0,   0, 0);
        add(0,0,0,0, 32'h800, 0, 1, 32'h800, 1, 0);
        add(0,0,0,1, 32'h0,   1, 0, 32'h0,   0, 0);

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i].rst, vecs[i].flush, vecs[i].halt, vecs[i].ready, vecs[i].pc, vecs[i].bubble);
            @(posedge CLK);
            #1;
            check_head($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_cnt, vecs[i].e_frz);
        end

        // wrap-around against a reference queue, then drain
        for (int i = 0; i < 26; i++) begin
            logic [31:0] pc;
            logic        rdy;
            logic        bub;
            bit          deq;
            bit          enq;
            bub = (i >= 20);
            pc  = bub ? 32'h0 : 32'h900 + 32'(4 * i);
            rdy = bub ? 1'b1 : logic'(i % 2);
            deq = (q.size() > 0) && rdy;
            enq = !bub && (q.size() < DEPTH);
            @(negedge CLK);
            drive(1'b0, 1'b0, 1'b0, rdy, pc, bub);
            @(posedge CLK);
            #1;
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(int'(pc));
            check_head($sformatf("wrap%0d", i), q.size() > 0,
                       q.size() > 0 ? 32'(q[0]) : 32'h0, q.size(), q.size() == DEPTH);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
